instr_fetch_decode: RTL
=======================

# instr_fetch_decode

Instruction fetch sequencer and instruction register (IR) for the multicycle MIPS datapath, directly upstream of the control unit. On a fetch request from the control unit it waits out the fixed memory read latency and latches the memory word into the IR. It then presents the split instruction fields plus a decoded instruction class and ALU function, and holds them until the control unit acknowledges.

## Interface
- MEM_LATENCY, 2, memory read latency in clock edges; legal range 1..15.
- clock  in  1  system clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- fetch_req  in  1  control unit requests a new instruction (PC already on the address bus).
- mem_rdata  in  32  memory read data.
- decode_ack  in  1  control unit has consumed the current instruction.
- busy  out  1  fetch in progress (WAIT state).
- instr_valid  out  1  IR holds a fresh, unconsumed instruction.
- instr  out  32  IR contents.
- opcode  out  6  instr[31:26].
- rs  out  5  instr[25:21].
- rt  out  5  instr[20:16].
- rd  out  5  instr[15:11].
- shamt  out  5  instr[10:6].
- funct  out  6  instr[5:0].
- imm16  out  16  instr[15:0].
- jaddr  out  26  instr[25:0].
- op_class  out  3  decoded class (op_class_t).
- alu_fn  out  3  ALU function (alu_fn_t: LOAD=0, ADD=1, SUB=2, AND=3, INC=4, NEG=5, XOR=6, COMP=7).
- illegal  out  1  unsupported encoding flag.

## Operation
- FSM states: IDLE, WAIT, HOLD. Reset state is IDLE.
- IDLE: busy=0, instr_valid=0.
  - fetch_req=1 -> WAIT; load cnt with MEM_LATENCY-1.
- WAIT: busy=1.
  - cnt!=0 -> decrement cnt.
  - cnt==0 -> IR <= mem_rdata; go to HOLD.
  - fetch_req is ignored while in WAIT.
- HOLD: instr_valid=1; IR is frozen.
  - decode_ack=1 with fetch_req=0 -> IDLE.
  - decode_ack=1 with fetch_req=1 -> WAIT (back-to-back fetch; cnt reloaded).
  - fetch_req=1 without decode_ack -> ignored; stay in HOLD.
- decode_ack outside HOLD: ignored.
- Field outputs are pure slices of the IR.
- op_class and alu_fn are combinational from the IR only, never from mem_rdata.
- Decode table (opcode 0 is R-type, selected by funct):
  - funct 0x20 add -> RTYPE, ADD.
  - funct 0x22 sub -> RTYPE, SUB.
  - funct 0x24 and -> RTYPE, AND.
  - funct 0x26 xor -> RTYPE, XOR.
  - funct 0x2A slt -> RTYPE, COMP.
  - funct 0x08 jr -> JUMP, LOAD.
  - funct 0x00 -> NONE (nop), LOAD.
  - opcode 0x23 lw -> LOAD, ADD.
  - opcode 0x2B sw -> STORE, ADD.
  - opcode 0x04 beq, 0x05 bne -> BRANCH, SUB.
  - opcode 0x02 j -> JUMP, LOAD.
  - opcode 0x08 addi -> IMM, ADD.
  - opcode 0x0F lui -> IMM, LOAD.
  - anything else -> see Configuration.

## Timing
- Reset (asynchronous, any state, including mid-WAIT):
  - state=IDLE, cnt=0, IR=0x00000000.
  - busy=0, instr_valid=0, illegal=0.
  - op_class=NONE, alu_fn=LOAD; all field outputs 0.
- Latency: fetch_req sampled high at edge E -> IR loaded at edge E+MEM_LATENCY -> instr_valid high in the cycle after that edge.
- With MEM_LATENCY=2 the sequence spans 3 cycles: request, wait, capture.
- mem_rdata is sampled only at the capture edge.
- busy is high for exactly MEM_LATENCY cycles per fetch.
- Back-to-back: ack+req at edge A -> next capture at edge A+MEM_LATENCY; instr_valid drops in the cycle after edge A.
- Fetch throughput: MEM_LATENCY+1 cycles per instruction.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - unlisted encodings decode to op_class ILLEGAL, alu_fn LOAD.
  - illegal = instr_valid AND class==ILLEGAL.
- ILLEGAL_TRAP_EN undefined:
  - unlisted encodings decode to NONE.
  - illegal is tied to 0; the port remains present.

## Structure
- Package cpu_pkg holds:
  - op_class_t {NONE, RTYPE, LOAD, STORE, BRANCH, JUMP, IMM, ILLEGAL}.
  - alu_fn_t (encoding as listed in Interface).
  - OPC_* and FN_* localparams for the opcodes/functs above.
  - fetch_state_t {IDLE, WAIT, HOLD}.
- Sub-module instr_decoder: purely combinational, instr[31:0] -> op_class, alu_fn.
  - The ILLEGAL_TRAP_EN switch lives in instr_decoder.
- Top level holds the FSM, latency counter and IR.

## Test plan
- Reset then idle: all outputs 0, op_class=NONE, busy=0; decode_ack pulses have no effect.
- MEM_LATENCY=2, fetch_req at edge 0, mem_rdata=0x8C430004 valid at edge 2 -> instr_valid from cycle 3 with:
  - op_class=LOAD, alu_fn=ADD.
  - rs=2, rt=3, imm16=0x0004.
  - busy high for exactly 2 cycles.
- HOLD without ack for 10 cycles while mem_rdata changes and fetch_req=1 -> IR stays 0x8C430004.
  - decode_ack alone -> IDLE.
- Back-to-back: ack+req in HOLD, next word 0x00A62022 -> RTYPE/SUB, rd=4; no IDLE cycle in between.
- Reset asserted mid-WAIT -> immediate IDLE, IR=0; a subsequent fetch completes normally.
- Word 0xFC000000:
  - with ILLEGAL_TRAP_EN: op_class=ILLEGAL, illegal=1 while valid.
  - without: op_class=NONE, illegal=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and encodings for the multicycle MIPS front end.
//   op_class_t    - decoded instruction class
//   alu_fn_t      - ALU function code handed to the control unit
//   fetch_state_t - fetch sequencer states
//   OPC_* / FN_*  - opcode and R-type funct encodings understood by the decoder
package cpu_pkg;

  typedef enum logic [2:0] {
    CLS_NONE    = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_JUMP    = 3'd5,
    CLS_IMM     = 3'd6,
    CLS_ILLEGAL = 3'd7
  } op_class_t;

  typedef enum logic [2:0] {
    ALU_LOAD = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_INC  = 3'd4,
    ALU_NEG  = 3'd5,
    ALU_XOR  = 3'd6,
    ALU_COMP = 3'd7
  } alu_fn_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_NOP = 6'h00;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: purely combinational class / ALU-function decode of an
// instruction word.
//   instr    in  32  instruction word (taken from the IR, never from memory)
//   op_class out     decoded class
//   alu_fn   out     ALU function
// Optional feature macro: ILLEGAL_TRAP_EN -- when defined, encodings not in
// the table decode to CLS_ILLEGAL; otherwise they decode to CLS_NONE.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output op_class_t   op_class,
  output alu_fn_t     alu_fn
);

`ifdef ILLEGAL_TRAP_EN
  localparam op_class_t UNLISTED_CLS = CLS_ILLEGAL;
`else
  localparam op_class_t UNLISTED_CLS = CLS_NONE;
`endif

  logic [5:0] opc;
  logic [5:0] fn;
  // Register/immediate fields play no part in classification.
  logic       unused_fields;

  assign opc           = instr[31:26];
  assign fn            = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    op_class = CLS_NONE;
    alu_fn   = ALU_LOAD;
    case (opc)
      OPC_RTYPE: begin
        case (fn)
          FN_ADD:  begin op_class = CLS_RTYPE; alu_fn = ALU_ADD;  end
          FN_SUB:  begin op_class = CLS_RTYPE; alu_fn = ALU_SUB;  end
          FN_AND:  begin op_class = CLS_RTYPE; alu_fn = ALU_AND;  end
          FN_XOR:  begin op_class = CLS_RTYPE; alu_fn = ALU_XOR;  end
          FN_SLT:  begin op_class = CLS_RTYPE; alu_fn = ALU_COMP; end
          FN_JR:   begin op_class = CLS_JUMP;  alu_fn = ALU_LOAD; end
          FN_NOP:  begin op_class = CLS_NONE;  alu_fn = ALU_LOAD; end
          default: begin op_class = UNLISTED_CLS; alu_fn = ALU_LOAD; end
        endcase
      end
      OPC_LW:   begin op_class = CLS_LOAD;   alu_fn = ALU_ADD;  end
      OPC_SW:   begin op_class = CLS_STORE;  alu_fn = ALU_ADD;  end
      OPC_BEQ,
      OPC_BNE:  begin op_class = CLS_BRANCH; alu_fn = ALU_SUB;  end
      OPC_J:    begin op_class = CLS_JUMP;   alu_fn = ALU_LOAD; end
      OPC_ADDI: begin op_class = CLS_IMM;    alu_fn = ALU_ADD;  end
      OPC_LUI:  begin op_class = CLS_IMM;    alu_fn = ALU_LOAD; end
      default:  begin op_class = UNLISTED_CLS; alu_fn = ALU_LOAD; end
    endcase
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: fetch sequencer + instruction register for the
// multicycle MIPS datapath.
//   MEM_LATENCY       memory read latency in clock edges (1..15)
//   clock, reset      rising-edge clock, async active-high reset
//   fetch_req   in    start a fetch (PC already on the address bus)
//   mem_rdata   in    memory read data, sampled only at the capture edge
//   decode_ack  in    control unit consumed the held instruction
//   busy        out   fetch in progress (WAIT)
//   instr_valid out   IR holds an unconsumed instruction (HOLD)
//   instr + fields    IR contents and pure slices of it
//   op_class/alu_fn   decode of the IR
//   illegal     out   held instruction is an unsupported encoding
// Optional feature macro: ILLEGAL_TRAP_EN (handled inside instr_decoder).
module instr_fetch_decode
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] mem_rdata,
  input  logic        decode_ack,
  output logic        busy,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] jaddr,
  output op_class_t   op_class,
  output alu_fn_t     alu_fn,
  output logic        illegal
);

  // Counter reloads with MEM_LATENCY-1 so capture lands exactly
  // MEM_LATENCY edges after the request edge.
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  fetch_state_t state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [31:0]  ir_q, ir_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ir_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ir_d        = ir_q;
    busy        = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_req) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ir_d    = mem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        // A request without ack is dropped; ack+req chains straight into WAIT.
        if (decode_ack) begin
          if (fetch_req) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign instr  = ir_q;
  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];
  assign imm16  = ir_q[15:0];
  assign jaddr  = ir_q[25:0];

  instr_decoder u_dec (
    .instr    (ir_q),
    .op_class (op_class),
    .alu_fn   (alu_fn)
  );

  // Without the trap option the decoder never yields CLS_ILLEGAL, so this is 0.
  assign illegal = instr_valid && (op_class == CLS_ILLEGAL);

endmodule
